// File: rtl/nes_pkg.sv
// =============================================================================
// Module      : nes_pkg
// Description : Shared NES pad constants, button indices and FSM encoding.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package nes_pkg;

    localparam int NES_BITS = 8;

    // Button bit positions, shared with the nesController poller
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } pad_state_t;

    function automatic logic [NES_BITS-1:0] shift_out(input logic [NES_BITS-1:0] v);
        return {v[NES_BITS-2:0], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/nes_pad_emulator_sync_edge.sv
// =============================================================================
// Module      : sync_edge
// Description : Multi-stage synchronizer with registered level/rise/fall.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;

    // level doubles as the previous-value register, so rise/fall line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            level  <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~level;
            fall   <= ~sync_q[SYNC_STAGES-1] & level;
        end
    end

endmodule

`default_nettype wire

// File: rtl/nes_pad_emulator.sv
// =============================================================================
// Module      : nes_pad_emulator
// Description : NES gamepad (4021 PISO) responder driving the active-low data line.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module nes_pad_emulator
    import nes_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NES_BITS-1:0] buttons,
    input  logic                latch,
    input  logic                clkIn,
    output logic                data,
    output logic                frameDone,
    output logic [7:0]          frameCount
);

    logic                latch_lvl;
    logic                latch_rise_unused;
    logic                latch_fall;
    logic                clk_lvl_unused;
    logic                clk_rise;
    logic                clk_fall_unused;

    pad_state_t          state;
    logic [NES_BITS-1:0] shift_reg;
    logic [3:0]          bit_cnt;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (latch),
        .level    (latch_lvl),
        .rise     (latch_rise_unused),
        .fall     (latch_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (clkIn),
        .level    (clk_lvl_unused),
        .rise     (clk_rise),
        .fall     (clk_fall_unused)
    );

    // data is computed from next-state values so it changes with the state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= 4'd0;
            data       <= 1'b1;
            frameDone  <= 1'b0;
            frameCount <= 8'd0;
        end else begin
            frameDone <= 1'b0;
            if (frameDone) begin
                frameCount <= frameCount + 8'd1;
            end

            if (latch_lvl) begin
                state     <= LOAD;
                shift_reg <= buttons;
                bit_cnt   <= 4'd0;
                data      <= ~buttons[BTN_A];
            end else begin
                case (state)
                    IDLE: begin
                        data <= 1'b1;
                    end
                    LOAD: begin
                        data <= ~shift_reg[BTN_A];
                        if (latch_fall) begin
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (clk_rise) begin
                            shift_reg <= shift_out(shift_reg);
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                state     <= DONE;
                                frameDone <= 1'b1;
                                data      <= 1'b0;
                            end else begin
                                data <= ~shift_reg[BTN_A-1];
                            end
                        end
                    end
                    DONE: begin
                        data <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        data  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
